burst_addr_gen: RTL
===================

Name: burst_addr_gen

Overview:
Parametrised address generator for the SDR/DDR SDRAM controller. It latches a host request (bank/row/column address plus transfer length) and splits it into burst-aligned column commands. It detects page ends, advances row and bank across page boundaries, and flags auto-precharge. It sits between the host request interface and the command sequencer.

Parameters:
BA_W, 2, bank address width
ROW_W, 12, row address width
COL_W, 9, column address width (page = 2^COL_W columns)
LEN_W, 9, transfer length width in beats

Ports:
clk  in  1  controller clock, all logic on posedge
reset1  in  1  asynchronous active-high reset
u_addr  in  BA_W+ROW_W+COL_W  host address {bank,row,col}
req  in  1  start pulse; sampled only in IDLE
req_len  in  LEN_W  transfer length in beats; 0 = request ignored
req_wr_n  in  1  0 write, 1 read; latched with req
bl_code  in  3  mode-reg burst length: 0→1, 1→2, 2→4, 3→8, 4-7→8
ap_en  in  1  enable auto-precharge; sampled with req
abort  in  1  synchronous abort
cmd_ack  in  1  sequencer accepted the current ACT/PRE/RW command
act_req  out  1  ACTIVATE needed
pre_req  out  1  explicit PRECHARGE needed
rw_req  out  1  read/write burst command valid
rw_wr_n  out  1  latched direction
sdc_ba  out  BA_W  current bank
row_ad  out  ROW_W  current row
col_ad  out  COL_W  current burst start column
beats  out  4  beats in current burst (1..8)
ap_flag  out  1  auto-precharge bit for current RW command
last_burst  out  1  current burst completes the transfer
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on completion
addr_wrap  out  1  one-cycle pulse when bank wraps from max to 0

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal rem, B, ap and wr latches cleared.
- States: IDLE, ACT, BURST, XROW, DONE. Exactly one of act_req/pre_req/rw_req is high in ACT/XROW/BURST respectively; none otherwise.
- IDLE: req=1 and req_len!=0 → latch bank/row/col, rem=req_len, B=decoded bl_code, ap_en, req_wr_n; next cycle ACT (act_req high at N+1). Otherwise stay. req outside IDLE is ignored.
- ACT: hold act_req until cmd_ack, then BURST.
- BURST: beats = min(B − (col & (B−1)), rem), combinational from registered col/rem. Bursts therefore never straddle a burst boundary or the page end. last_burst = (beats == rem). page_end = (col + beats == 2^COL_W). ap_flag = ap & (last_burst | page_end).
- BURST on cmd_ack: rem −= beats; col += beats (mod 2^COL_W).
  - rem reaches 0 → DONE.
  - Else if page_end: row += 1; on row carry, bank += 1 (mod 2^BA_W) and addr_wrap pulses when bank was all-ones. Then go ACT if ap_flag, else XROW.
  - Else stay BURST.
- XROW: pre_req high with the old bank/row still driven until cmd_ack. New row/bank apply on entry to ACT.
- DONE: done=1 for one cycle, then IDLE. The next req is accepted in the cycle after DONE.
- abort=1 in any state → IDLE next cycle, done not pulsed. abort has priority over cmd_ack.
- cmd_ack in IDLE/DONE is ignored. All counters are unsigned, truncated to the declared widths.

Test Plan:
- bl=4, bank 1, row 0x005, col 0x010, len 8, ap_en=1 → ACT(b1,r5); RW col 0x010 beats 4 ap 0; RW col 0x014 beats 4 ap 1 last; done pulse; busy falls.
- Misaligned: col 0x011, bl=4, len 6 → RW 0x011 beats 3, RW 0x014 beats 3 last.
- Page cross, ap_en=0: row 0x005, col 0x1FC, bl=4, len 8 → RW 0x1FC beats 4 ap 0; pre_req (r5); ACT r6; RW 0x000 beats 4 last.
- Page cross, ap_en=1, bank 3 row 0xFFF col 0x1FC, len 8 → first RW ap 1, no XROW, addr_wrap pulse, ACT b0 r0, RW col 0x000.
- bl_code=0, len 3 → three 1-beat bursts at col c, c+1, c+2.
- req while busy ignored. abort mid-BURST → IDLE next cycle with no done pulse. reset1 asserted mid-BURST → outputs 0 without a clock edge.

Source files
------------

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : burst_addr_gen
// Purpose  : Latches a host SDRAM request ({bank,row,col} + length) and splits
//            it into burst-aligned column commands. Detects page ends, steps
//            row/bank across page boundaries and flags auto-precharge.
// Ports    : clk, reset1 (async, active high)
//            host side : u_addr, req, req_len, req_wr_n, bl_code, ap_en, abort
//            sequencer : cmd_ack in; act_req, pre_req, rw_req, rw_wr_n,
//                        sdc_ba, row_ad, col_ad, beats, ap_flag, last_burst out
//            status    : busy, done, addr_wrap
// Revision : 1.0 - initial release
// ============================================================================
module burst_addr_gen #(
  parameter int BA_W  = 2,
  parameter int ROW_W = 12,
  parameter int COL_W = 9,
  parameter int LEN_W = 9
) (
  input  logic                        clk,
  input  logic                        reset1,
  input  logic [BA_W+ROW_W+COL_W-1:0] u_addr,
  input  logic                        req,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        req_wr_n,
  input  logic [2:0]                  bl_code,
  input  logic                        ap_en,
  input  logic                        abort,
  input  logic                        cmd_ack,
  output logic                        act_req,
  output logic                        pre_req,
  output logic                        rw_req,
  output logic                        rw_wr_n,
  output logic [BA_W-1:0]             sdc_ba,
  output logic [ROW_W-1:0]            row_ad,
  output logic [COL_W-1:0]            col_ad,
  output logic [3:0]                  beats,
  output logic                        ap_flag,
  output logic                        last_burst,
  output logic                        busy,
  output logic                        done,
  output logic                        addr_wrap
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACT   = 3'd1,
    S_BURST = 3'd2,
    S_XROW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BA_W-1:0]    ba_q, ba_d, nba_q, nba_d;
  logic [ROW_W-1:0]   row_q, row_d, nrow_q, nrow_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [3:0]         bl_q, bl_d;
  logic               ap_q, ap_d, wr_q, wr_d, wrap_q, wrap_d;

  // Burst sizing, derived from the registered column and remaining count.
  logic [3:0]         w_off, w_first, w_beats;
  logic [COL_W:0]     w_col_sum;
  logic               w_page_end, w_last, w_apf;
  logic [LEN_W-1:0]   w_rem_nxt;
  logic [ROW_W:0]     w_row_inc;
  logic [BA_W-1:0]    w_ba_inc;
  logic [3:0]         w_bl_dec;

  // Offset inside the current burst-length window; B is a power of two.
  assign w_off      = {1'b0, col_q[2:0]} & (bl_q - 4'd1);
  assign w_first    = bl_q - w_off;
  assign w_beats    = (rem_q < LEN_W'(w_first)) ? rem_q[3:0] : w_first;
  assign w_col_sum  = {1'b0, col_q} + (COL_W+1)'(w_beats);
  assign w_page_end = w_col_sum[COL_W];
  assign w_last     = (LEN_W'(w_beats) == rem_q);
  assign w_apf      = ap_q & (w_last | w_page_end);
  assign w_rem_nxt  = rem_q - LEN_W'(w_beats);
  assign w_row_inc  = {1'b0, row_q} + (ROW_W+1)'(1);
  assign w_ba_inc   = ba_q + BA_W'(w_row_inc[ROW_W]);

  always_comb begin
    case (bl_code)
      3'd0:    w_bl_dec = 4'd1;
      3'd1:    w_bl_dec = 4'd2;
      3'd2:    w_bl_dec = 4'd4;
      default: w_bl_dec = 4'd8;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    nba_d   = nba_q;
    nrow_d  = nrow_q;
    rem_d   = rem_q;
    bl_d    = bl_q;
    ap_d    = ap_q;
    wr_d    = wr_q;
    wrap_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && (req_len != '0)) begin
            {ba_d, row_d, col_d} = u_addr;
            rem_d   = req_len;
            bl_d    = w_bl_dec;
            ap_d    = ap_en;
            wr_d    = req_wr_n;
            state_d = S_ACT;
          end
        end
        S_ACT: begin
          if (cmd_ack) state_d = S_BURST;
        end
        S_BURST: begin
          if (cmd_ack) begin
            rem_d = w_rem_nxt;
            col_d = w_col_sum[COL_W-1:0];
            if (w_rem_nxt == '0) begin
              state_d = S_DONE;
            end else if (w_page_end) begin
              wrap_d = w_row_inc[ROW_W] & (&ba_q);
              if (w_apf) begin
                // Auto-precharge closed the row: activate the next one directly.
                row_d   = w_row_inc[ROW_W-1:0];
                ba_d    = w_ba_inc;
                state_d = S_ACT;
              end else begin
                // Old row must stay visible for the explicit precharge.
                nrow_d  = w_row_inc[ROW_W-1:0];
                nba_d   = w_ba_inc;
                state_d = S_XROW;
              end
            end
          end
        end
        S_XROW: begin
          if (cmd_ack) begin
            row_d   = nrow_q;
            ba_d    = nba_q;
            state_d = S_ACT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset1) begin
    if (reset1) begin
      state_q <= S_IDLE;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      nba_q   <= '0;
      nrow_q  <= '0;
      rem_q   <= '0;
      bl_q    <= '0;
      ap_q    <= 1'b0;
      wr_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
      nba_q   <= nba_d;
      nrow_q  <= nrow_d;
      rem_q   <= rem_d;
      bl_q    <= bl_d;
      ap_q    <= ap_d;
      wr_q    <= wr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign act_req    = (state_q == S_ACT);
  assign pre_req    = (state_q == S_XROW);
  assign rw_req     = (state_q == S_BURST);
  assign rw_wr_n    = wr_q;
  assign sdc_ba     = ba_q;
  assign row_ad     = row_q;
  assign col_ad     = col_q;
  assign beats      = rw_req ? w_beats : 4'd0;
  assign ap_flag    = rw_req & w_apf;
  assign last_burst = rw_req & w_last;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_wrap  = wrap_q;

endmodule
`default_nettype wire
